// File: rtl/pool_pkg.sv
// rtl/pool_pkg.sv - shared types and constants for the 2x2 streaming pooling block
`timescale 1ns/1ps
package pool_pkg;

  // Default signed element width.
  localparam int POOL_DATA_W = 16;

  // Values of the mode input.
  localparam logic POOL_MODE_MAX = 1'b0;
  localparam logic POOL_MODE_AVG = 1'b1;

  // FIRST: no column held; SECOND: first column of the pair is held.
  typedef enum logic {
    POOL_FIRST  = 1'b0,
    POOL_SECOND = 1'b1
  } pool_state_t;

endpackage

// File: rtl/pool_window4.sv
// rtl/pool_window4.sv - combinational 2x2 window reducer (max, plus average when POOL2D_AVG_EN is defined)
`timescale 1ns/1ps
module pool_window4
  import pool_pkg::*;
#(
  parameter int DATA_W = POOL_DATA_W
) (
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  input  logic signed [DATA_W-1:0] c,
  input  logic signed [DATA_W-1:0] d,
  input  logic                     mode,
  output logic signed [DATA_W-1:0] pooled
);

  logic signed [DATA_W-1:0] max_ab;
  logic signed [DATA_W-1:0] max_cd;
  logic signed [DATA_W-1:0] max_all;

  // Signed maximum as a two-level comparison tree.
  always_comb begin
    max_ab  = (a > b) ? a : b;
    max_cd  = (c > d) ? c : d;
    max_all = (max_ab > max_cd) ? max_ab : max_cd;
  end

`ifdef POOL2D_AVG_EN
  logic signed [DATA_W+1:0] sum4;

  // Two guard bits hold the four-way sum; the arithmetic shift floors toward minus infinity.
  always_comb begin
    sum4 = {{2{a[DATA_W-1]}}, a} + {{2{b[DATA_W-1]}}, b}
         + {{2{c[DATA_W-1]}}, c} + {{2{d[DATA_W-1]}}, d};
    if (mode == POOL_MODE_AVG) begin
      pooled = DATA_W'(sum4 >>> 2);
    end else begin
      pooled = max_all;
    end
  end
`else
  // Only max pooling is built; mode has no effect on the result.
  logic unused_mode;
  assign unused_mode = mode;

  // Result is always the maximum.
  always_comb begin
    pooled = max_all;
  end
`endif

endmodule

// File: rtl/pool2d_stream.sv
// rtl/pool2d_stream.sv - streaming 2x2 max/average pooling over column pairs; POOL2D_AVG_EN enables average mode
`timescale 1ns/1ps
module pool2d_stream
  import pool_pkg::*;
#(
  parameter int DATA_W = POOL_DATA_W,
  parameter int ROWS   = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           valid_in,
  output logic                           ready_in,
  input  logic                           last_in,
  input  logic                           mode,
  input  logic [ROWS-1:0][DATA_W-1:0]    input_column,
  output logic                           valid_out,
  input  logic                           ready_out,
  output logic [ROWS/2-1:0][DATA_W-1:0]  output_column,
  output logic                           last_out
);

  localparam int PAIRS = ROWS / 2;

  generate
    if (ROWS < 2 || (ROWS % 2) != 0) begin : g_rows_check
      $error("pool2d_stream: ROWS must be even and at least 2");
    end
  endgenerate

  pool_state_t                     state;
  logic [ROWS-1:0][DATA_W-1:0]     held_column;
  logic [PAIRS-1:0][DATA_W-1:0]    pooled;
  logic                            accept;
  logic                            out_xfer;

  // A first column is always taken; a second column needs room in the output register.
  assign ready_in = (state == POOL_FIRST) || !valid_out || ready_out;
  assign accept   = valid_in && ready_in;
  assign out_xfer = valid_out && ready_out;

  // One window per output element: rows 2k and 2k+1 of the held and incoming columns.
  genvar k;
  generate
    for (k = 0; k < PAIRS; k++) begin : g_window
      pool_window4 #(
        .DATA_W (DATA_W)
      ) u_window (
        .a      (held_column[2*k]),
        .b      (held_column[2*k+1]),
        .c      (input_column[2*k]),
        .d      (input_column[2*k+1]),
        .mode   (mode),
        .pooled (pooled[k])
      );
    end
  endgenerate

  // Pairing FSM with registered output; a new result may load on the same cycle the old one leaves.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= POOL_FIRST;
      held_column   <= '0;
      valid_out     <= 1'b0;
      last_out      <= 1'b0;
      output_column <= '0;
    end else begin
      if (out_xfer) begin
        valid_out <= 1'b0;
      end
      case (state)
        POOL_FIRST: begin
          // A lone trailing column of an odd-width row is dropped.
          if (accept && !last_in) begin
            held_column <= input_column;
            state       <= POOL_SECOND;
          end
        end
        POOL_SECOND: begin
          if (accept) begin
            output_column <= pooled;
            valid_out     <= 1'b1;
            last_out      <= last_in;
            state         <= POOL_FIRST;
          end
        end
      endcase
    end
  end

endmodule
